// File: rtl/sub_sat_pipe.sv
// Pipelined A-B subtractor with per-operation saturate/wrap mode.
// Stage 1 does the arithmetic; the remaining stages carry the result and its flags unchanged.
module sub_sat_pipe #(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned STAGES    = 2,
  parameter bit          SIGNED    = 1'b0
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 En,
  input  logic                 InValid,
  input  logic [DATAWIDTH-1:0] A,
  input  logic [DATAWIDTH-1:0] B,
  input  logic                 Sat,
  output logic                 OutValid,
  output logic [DATAWIDTH-1:0] Diff,
  output logic                 Borrow,
  output logic                 Ovf
);

  localparam int unsigned W = DATAWIDTH;

  logic [W:0]   diff_ext;
  logic [W-1:0] wrapped;
  logic         borrow_s1;
  logic         ovf_s1;
  logic [W-1:0] result_s1;
  logic [W-1:0] max_pos;
  logic [W-1:0] max_neg;

  always_comb begin
    // The extra top bit of the zero-extended difference is the unsigned borrow.
    diff_ext  = {1'b0, A} - {1'b0, B};
    wrapped   = diff_ext[W-1:0];
    borrow_s1 = diff_ext[W];
    max_pos   = {1'b0, {(W-1){1'b1}}};
    max_neg   = {1'b1, {(W-1){1'b0}}};
    if (SIGNED) begin
      ovf_s1 = (A[W-1] ^ B[W-1]) & (wrapped[W-1] ^ A[W-1]);
    end else begin
      ovf_s1 = borrow_s1;
    end
    result_s1 = wrapped;
    if (Sat && ovf_s1) begin
      if (!SIGNED) begin
        result_s1 = '0;
      end else if (A[W-1]) begin
        result_s1 = max_neg;
      end else begin
        result_s1 = max_pos;
      end
    end
  end

  logic [STAGES-1:0]        vld_q;
  logic [STAGES-1:0][W-1:0] diff_q;
  logic [STAGES-1:0]        borrow_q;
  logic [STAGES-1:0]        ovf_q;

  // Data registers load only behind a valid bit, so bubbles never disturb the held result.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      vld_q    <= '0;
      diff_q   <= '0;
      borrow_q <= '0;
      ovf_q    <= '0;
    end else if (En) begin
      vld_q[0] <= InValid;
      if (InValid) begin
        diff_q[0]   <= result_s1;
        borrow_q[0] <= borrow_s1;
        ovf_q[0]    <= ovf_s1;
      end
      for (int i = 1; i < STAGES; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          diff_q[i]   <= diff_q[i-1];
          borrow_q[i] <= borrow_q[i-1];
          ovf_q[i]    <= ovf_q[i-1];
        end
      end
    end
  end

  // A result is presented only in an enabled cycle; it leaves the last stage on that same edge,
  // so each operation is reported exactly once even across stalls.
  assign OutValid = vld_q[STAGES-1] & En;
  assign Diff     = diff_q[STAGES-1];
  assign Borrow   = borrow_q[STAGES-1];
  assign Ovf      = ovf_q[STAGES-1];

endmodule

// File: tb/tb_sub_sat_pipe.sv
// Directed bench for sub_sat_pipe: unsigned and signed instances share the same stimulus.
module tb_sub_sat_pipe;

  logic       clk;
  logic       rst;
  logic       en;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic       sat;

  logic       ov_u;
  logic [7:0] diff_u;
  logic       borrow_u;
  logic       ovf_u;
  logic       ov_s;
  logic [7:0] diff_s;
  logic       borrow_s;
  logic       ovf_s;

  int n_tests = 0;
  int n_fail  = 0;

  sub_sat_pipe #(
    .DATAWIDTH(8),
    .STAGES   (2),
    .SIGNED   (1'b0)
  ) u_dut_u (
    .Clk     (clk),
    .Rst     (rst),
    .En      (en),
    .InValid (in_valid),
    .A       (a),
    .B       (b),
    .Sat     (sat),
    .OutValid(ov_u),
    .Diff    (diff_u),
    .Borrow  (borrow_u),
    .Ovf     (ovf_u)
  );

  sub_sat_pipe #(
    .DATAWIDTH(8),
    .STAGES   (2),
    .SIGNED   (1'b1)
  ) u_dut_s (
    .Clk     (clk),
    .Rst     (rst),
    .En      (en),
    .InValid (in_valid),
    .A       (a),
    .B       (b),
    .Sat     (sat),
    .OutValid(ov_s),
    .Diff    (diff_s),
    .Borrow  (borrow_s),
    .Ovf     (ovf_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs, then wait to the sampling point of that cycle.
  task automatic set_cyc(input logic e, input logic iv, input logic [7:0] aa, input logic [7:0] bb,
                         input logic s);
    en       = e;
    in_valid = iv;
    a        = aa;
    b        = bb;
    sat      = s;
    @(negedge clk);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one op, insert a bubble, then check both instances at the expected output cycle.
  task automatic op_vec(input string tag, input logic [7:0] aa, input logic [7:0] bb,
                        input logic s, input logic [7:0] exp_du, input logic exp_bo,
                        input logic exp_ou, input logic [7:0] exp_ds, input logic exp_os);
    set_cyc(1'b1, 1'b1, aa, bb, s);
    tick();
    set_cyc(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    check_eq({tag, "/lat_ov"}, ov_u, 0);
    tick();
    set_cyc(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    check_eq({tag, "/u_ov"}, ov_u, 1);
    check_eq({tag, "/u_diff"}, diff_u, exp_du);
    check_eq({tag, "/u_borrow"}, borrow_u, exp_bo);
    check_eq({tag, "/u_ovf"}, ovf_u, exp_ou);
    check_eq({tag, "/s_ov"}, ov_s, 1);
    check_eq({tag, "/s_diff"}, diff_s, exp_ds);
    check_eq({tag, "/s_borrow"}, borrow_s, exp_bo);
    check_eq({tag, "/s_ovf"}, ovf_s, exp_os);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0;
    in_valid = 1'b0;
    a = 8'h00;
    b = 8'h00;
    sat = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    set_cyc(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    check_eq("rst/ov", ov_u, 0);
    check_eq("rst/diff", diff_u, 8'h00);
    check_eq("rst/borrow", borrow_u, 0);
    check_eq("rst/ovf", ovf_u, 0);
    tick();

    //     tag         A      B      Sat   Du     Bo    Ou    Ds     Os
    op_vec("u_wrap",   8'h05, 8'h07, 1'b0, 8'hFE, 1'b1, 1'b1, 8'hFE, 1'b0);
    op_vec("u_sat",    8'h05, 8'h07, 1'b1, 8'h00, 1'b1, 1'b1, 8'hFE, 1'b0);
    op_vec("no_ovf",   8'h09, 8'h04, 1'b1, 8'h05, 1'b0, 1'b0, 8'h05, 1'b0);
    op_vec("s_negsat", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b0, 1'b0, 8'h80, 1'b1);
    op_vec("s_possat", 8'h7F, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b1, 8'h7F, 1'b1);
    op_vec("s_wrap",   8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 8'h7F, 1'b1);
    op_vec("zero",     8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);

    // Throughput with a bubble: (10,3), bubble, (20,5).
    set_cyc(1'b1, 1'b1, 8'd10, 8'd3, 1'b0);
    tick();
    set_cyc(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
    tick();
    set_cyc(1'b1, 1'b1, 8'd20, 8'd5, 1'b0);
    check_eq("thru/c2_ov", ov_u, 1);
    check_eq("thru/c2_diff", diff_u, 8'h07);
    tick();
    set_cyc(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
    check_eq("thru/c3_ov", ov_u, 0);
    check_eq("thru/c3_diff", diff_u, 8'h07);
    tick();
    set_cyc(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
    check_eq("thru/c4_ov", ov_u, 1);
    check_eq("thru/c4_diff", diff_u, 8'h0F);
    tick();

    // Stall: two ops, then En=0 for 3 cycles with junk on the inputs.
    set_cyc(1'b1, 1'b1, 8'd30, 8'd10, 1'b0);
    tick();
    set_cyc(1'b1, 1'b1, 8'd50, 8'd8, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_cyc(1'b0, 1'b1, 8'hFF, 8'h00, 1'b1);
      check_eq("stall/ov", ov_u, 0);
      tick();
    end
    set_cyc(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
    check_eq("stall/r1_ov", ov_u, 1);
    check_eq("stall/r1_diff", diff_u, 8'h14);
    tick();
    set_cyc(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
    check_eq("stall/r2_ov", ov_u, 1);
    check_eq("stall/r2_diff", diff_u, 8'h2A);
    tick();
    set_cyc(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
    check_eq("stall/after_ov", ov_u, 0);
    check_eq("stall/after_diff", diff_u, 8'h2A);
    tick();

    // Reset with two ops in flight (held there by a stall cycle).
    set_cyc(1'b1, 1'b1, 8'h01, 8'h02, 1'b0);
    tick();
    set_cyc(1'b1, 1'b1, 8'h03, 8'h05, 1'b0);
    tick();
    set_cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    check_eq("rmid/hold_ov", ov_u, 0);
    tick();
    rst = 1'b1;
    set_cyc(1'b1, 1'b1, 8'hAA, 8'h00, 1'b0);
    tick();
    rst = 1'b0;
    set_cyc(1'b1, 1'b1, 8'h33, 8'h11, 1'b0);
    check_eq("rmid/c0_ov", ov_u, 0);
    check_eq("rmid/c0_diff", diff_u, 8'h00);
    check_eq("rmid/c0_borrow", borrow_u, 0);
    check_eq("rmid/c0_ovf", ovf_u, 0);
    check_eq("rmid/c0_sdiff", diff_s, 8'h00);
    tick();
    set_cyc(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    check_eq("rmid/c1_ov", ov_u, 0);
    tick();
    set_cyc(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    check_eq("rmid/c2_ov", ov_u, 1);
    check_eq("rmid/c2_diff", diff_u, 8'h22);
    check_eq("rmid/c2_borrow", borrow_u, 0);
    tick();
    set_cyc(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    check_eq("rmid/c3_ov", ov_u, 0);
    check_eq("rmid/c3_diff", diff_u, 8'h22);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
